// File: rtl/ex_mem_elastic_reg.sv
// EX/MEM pipeline register with valid/ready handshake and a one-entry skid.
// The main entry drives the MEM side; the skid entry catches an accept made while MEM stalls.
module ex_mem_elastic_reg #(
  parameter int XLEN  = 64,
  parameter int RD_W  = 5,
  parameter int F3_W  = 3,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [RD_W-1:0]  in_rd,
  input  logic [4:0]       in_ctrl,
  input  logic [XLEN-1:0]  in_target,
  input  logic [XLEN-1:0]  in_result,
  input  logic             in_zero,
  input  logic [XLEN-1:0]  in_wdata,
  input  logic [F3_W-1:0]  in_funct3,
  input  logic             in_pos,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [RD_W-1:0]  out_rd,
  output logic [4:0]       out_ctrl,
  output logic [XLEN-1:0]  out_target,
  output logic [XLEN-1:0]  out_result,
  output logic             out_zero,
  output logic [XLEN-1:0]  out_wdata,
  output logic [F3_W-1:0]  out_funct3,
  output logic             out_pos,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef struct packed {
    logic [RD_W-1:0] rd;
    logic [4:0]      ctrl;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] result;
    logic            zero;
    logic [XLEN-1:0] wdata;
    logic [F3_W-1:0] funct3;
    logic            pos;
  } ent_t;

  ent_t in_e;
  ent_t main_q;
  ent_t skid_q;
  logic main_valid;
  logic skid_valid;
  logic accept;
  logic emit;

  assign in_e = {in_rd, in_ctrl, in_target, in_result,
                 in_zero, in_wdata, in_funct3, in_pos};

  // in_ready comes straight from the skid flop: no path from out_ready.
  assign in_ready = !skid_valid;
  assign accept   = in_valid && in_ready;
  assign emit     = main_valid && out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      stall_cnt  <= '0;
    end else begin
      if (main_valid && !out_ready && !flush && stall_cnt != '1)
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush) begin
        main_valid  <= 1'b0;
        skid_valid  <= 1'b0;
        main_q.ctrl <= '0;
        skid_q.ctrl <= '0;
      end else if (skid_valid) begin
        // in_ready is low here, so only the skid-to-main move can happen.
        if (emit) begin
          main_q     <= skid_q;
          skid_valid <= 1'b0;
        end
      end else if (accept) begin
        if (!main_valid || emit) begin
          main_q     <= in_e;
          main_valid <= 1'b1;
        end else begin
          skid_q     <= in_e;
          skid_valid <= 1'b1;
        end
      end else if (emit) begin
        main_valid <= 1'b0;
      end
    end
  end

  assign out_valid  = main_valid;
  assign out_rd     = main_q.rd;
  assign out_ctrl   = main_q.ctrl & {5{main_valid}};
  assign out_target = main_q.target;
  assign out_result = main_q.result;
  assign out_zero   = main_q.zero;
  assign out_wdata  = main_q.wdata;
  assign out_funct3 = main_q.funct3;
  assign out_pos    = main_q.pos;

endmodule

// File: tb/tb_ex_mem_elastic_reg.sv
// Bench for ex_mem_elastic_reg (XLEN=32, CNT_W=4 build).
// Reference model is a bounded FIFO queue plus a saturating counter.
module tb_ex_mem_elastic_reg;

  localparam int XLEN  = 32;
  localparam int RD_W  = 5;
  localparam int F3_W  = 3;
  localparam int CNT_W = 4;
  localparam int SMAX  = 15;

  typedef struct packed {
    logic [RD_W-1:0] rd;
    logic [4:0]      ctrl;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] result;
    logic            zero;
    logic [XLEN-1:0] wdata;
    logic [F3_W-1:0] funct3;
    logic            pos;
  } ent_t;

  logic clk = 1'b0;
  logic reset;
  logic in_valid;
  logic in_ready;
  logic [RD_W-1:0] in_rd;
  logic [4:0] in_ctrl;
  logic [XLEN-1:0] in_target;
  logic [XLEN-1:0] in_result;
  logic in_zero;
  logic [XLEN-1:0] in_wdata;
  logic [F3_W-1:0] in_funct3;
  logic in_pos;
  logic flush;
  logic out_valid;
  logic out_ready;
  logic [RD_W-1:0] out_rd;
  logic [4:0] out_ctrl;
  logic [XLEN-1:0] out_target;
  logic [XLEN-1:0] out_result;
  logic out_zero;
  logic [XLEN-1:0] out_wdata;
  logic [F3_W-1:0] out_funct3;
  logic out_pos;
  logic [CNT_W-1:0] stall_cnt;

  ex_mem_elastic_reg #(
    .XLEN(XLEN), .RD_W(RD_W), .F3_W(F3_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rd(in_rd), .in_ctrl(in_ctrl),
    .in_target(in_target), .in_result(in_result),
    .in_zero(in_zero), .in_wdata(in_wdata),
    .in_funct3(in_funct3), .in_pos(in_pos),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rd(out_rd), .out_ctrl(out_ctrl),
    .out_target(out_target), .out_result(out_result),
    .out_zero(out_zero), .out_wdata(out_wdata),
    .out_funct3(out_funct3), .out_pos(out_pos),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  ent_t q[$];
  int   scnt;
  int   n_cmp;
  int   n_bad;

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic ent_t observed();
    ent_t o;
    o = {out_rd, out_ctrl, out_target, out_result,
         out_zero, out_wdata, out_funct3, out_pos};
    return o;
  endfunction

  function automatic ent_t rnd_ent();
    ent_t e;
    e.rd     = RD_W'($urandom);
    e.ctrl   = 5'($urandom);
    e.target = $urandom;
    e.result = $urandom;
    e.zero   = 1'($urandom);
    e.wdata  = $urandom;
    e.funct3 = F3_W'($urandom);
    e.pos    = 1'($urandom);
    return e;
  endfunction

  function automatic ent_t mk(input logic [XLEN-1:0] res,
                              input logic [4:0] c);
    ent_t e;
    e = rnd_ent();
    e.result = res;
    e.ctrl   = c;
    return e;
  endfunction

  task automatic check_all();
    chk("out_valid", 128'(out_valid), 128'(q.size() > 0));
    chk("in_ready", 128'(in_ready), 128'(q.size() < 2));
    chk("stall_cnt", 128'(stall_cnt), 128'(scnt));
    if (q.size() > 0) chk("head", 128'(observed()), 128'(q[0]));
    else chk("ctrl_idle", 128'(out_ctrl), 128'(0));
  endtask

  // One clock: drive, advance the model across the edge, then check.
  task automatic step(input logic v, input ent_t e,
                      input logic ordy, input logic fl);
    int  n;
    logic acc;
    logic em;
    in_valid  = v;
    in_rd     = e.rd;
    in_ctrl   = e.ctrl;
    in_target = e.target;
    in_result = e.result;
    in_zero   = e.zero;
    in_wdata  = e.wdata;
    in_funct3 = e.funct3;
    in_pos    = e.pos;
    out_ready = ordy;
    flush     = fl;
    n   = q.size();
    acc = v && (n < 2);
    em  = (n > 0) && ordy;
    @(posedge clk);
    if (fl) q.delete();
    else begin
      if (em) void'(q.pop_front());
      if (acc) q.push_back(e);
    end
    if (n > 0 && !ordy && !fl && scnt < SMAX) scnt++;
    #1;
    check_all();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    q.delete();
    scnt = 0;
    chk("rst_fields", 128'(observed()), 128'(0));
    check_all();
    @(negedge clk);
    reset = 1'b0;
  endtask

  ent_t a, b, c, d;

  initial begin
    n_cmp = 0;
    n_bad = 0;
    scnt  = 0;
    reset = 1'b1;
    in_valid = 1'b0; in_rd = '0; in_ctrl = '0; in_target = '0;
    in_result = '0; in_zero = 1'b0; in_wdata = '0; in_funct3 = '0;
    in_pos = 1'b0; flush = 1'b0; out_ready = 1'b0;
    #2;
    do_reset();

    // streaming at full throughput
    for (int i = 1; i <= 4; i++)
      step(1'b1, mk(XLEN'(i * 16), 5'b00001), 1'b1, 1'b0);
    step(1'b0, rnd_ent(), 1'b1, 1'b0);
    chk("stream_stall", 128'(stall_cnt), 128'(0));

    // back-pressure with A, B, C
    a = mk(32'h111, 5'b00011);
    b = mk(32'h222, 5'b00101);
    c = mk(32'h333, 5'b01001);
    step(1'b1, a, 1'b0, 1'b0);
    step(1'b1, b, 1'b0, 1'b0);
    chk("skid_full", 128'(in_ready), 128'(0));
    step(1'b1, c, 1'b0, 1'b0);
    chk("c_blocked", 128'(out_result), 128'(32'h111));
    step(1'b1, c, 1'b1, 1'b0);
    chk("b_next", 128'(out_result), 128'(32'h222));
    step(1'b1, c, 1'b1, 1'b0);
    chk("c_next", 128'(out_result), 128'(32'h333));
    step(1'b0, c, 1'b1, 1'b0);
    chk("stall_two", 128'(stall_cnt), 128'(2));

    // flush with both entries full
    step(1'b1, mk(32'h444, 5'b11111), 1'b0, 1'b0);
    step(1'b1, mk(32'h555, 5'b11111), 1'b0, 1'b0);
    d = mk(32'h666, 5'b11111);
    step(1'b1, d, 1'b0, 1'b1);
    chk("flush_valid", 128'(out_valid), 128'(0));
    chk("flush_ctrl", 128'(out_ctrl), 128'(0));
    step(1'b0, d, 1'b1, 1'b0);
    chk("flush_gone", 128'(out_valid), 128'(0));

    // counter saturation
    do_reset();
    step(1'b1, mk(32'h777, 5'b00001), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b0, rnd_ent(), 1'b0, 1'b0);
    chk("sat", 128'(stall_cnt), 128'(SMAX));

    // asynchronous reset between edges while stalled
    step(1'b1, mk(32'h888, 5'b00001), 1'b0, 1'b0);
    #3;
    reset = 1'b1;
    #1;
    q.delete();
    scnt = 0;
    chk("arst_valid", 128'(out_valid), 128'(0));
    chk("arst_cnt", 128'(stall_cnt), 128'(0));
    chk("arst_ready", 128'(in_ready), 128'(1));
    @(negedge clk);
    reset = 1'b0;

    // full-width values pass bit-exact
    step(1'b1, mk(32'hFFFF_FFFF, 5'b00001), 1'b1, 1'b0);
    chk("all_ones", 128'(out_result), 128'(32'hFFFF_FFFF));
    step(1'b1, mk(32'h8000_0000, 5'b00001), 1'b1, 1'b0);
    chk("msb_only", 128'(out_result), 128'(32'h8000_0000));

    // randomized traffic
    do_reset();
    for (int i = 0; i < 500; i++)
      step(($urandom % 4) != 0, rnd_ent(),
           ($urandom % 3) != 0, ($urandom % 25) == 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ex_mem_elastic_reg.md
# ex_mem_elastic_reg

Parametrised EX/MEM pipeline register with a valid/ready handshake and a 2-entry skid buffer, so the memory stage can back-pressure execute without losing an in-flight instruction. It sits between the ALU/branch-adder outputs and the data-memory/writeback path. It generalises the fixed 64-bit latch with XLEN and field widths as parameters. It adds stall handling, whole-entry flush, control-bit gating and a saturating stall counter.

## Interface
- XLEN, 64, width of branch target, ALU result and store data
- RD_W, 5, destination register index width
- F3_W, 3, funct3 width
- CNT_W, 16, stall counter width
- clk  in  1  pipeline clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- in_valid  in  1  EX presents an instruction
- in_ready  out  1  register can accept (registered, = !skid_valid)
- in_rd  in  RD_W  destination register
- in_ctrl  in  5  {Branch, MemWrite, MemRead, MemtoReg, RegWrite}, bit 4..0
- in_target  in  XLEN  branch target from adder
- in_result  in  XLEN  ALU result
- in_zero  in  1  ALU zero flag
- in_wdata  in  XLEN  store data
- in_funct3  in  F3_W  funct3
- in_pos  in  1  branch-polarity flag
- flush  in  1  synchronous kill of all held entries
- out_valid  out  1  MEM entry valid
- out_ready  in  1  MEM stage consumes entry
- out_rd, out_ctrl, out_target, out_result, out_zero, out_wdata, out_funct3, out_pos  out  (matching widths)  head entry fields
- stall_cnt  out  CNT_W  saturating count of back-pressure cycles

## Operation
- Storage: main entry (drives outputs) + skid entry, each with a valid bit.
- Accept: in_valid && in_ready. Emit: out_valid && out_ready.
- Main empty, or main emitting this cycle, with skid empty: accepted input loads main.
- Main held (out_valid && !out_ready) and input accepted: input loads skid; in_ready = 0 from next cycle.
- Skid full and main emitting: skid moves to main, skid_valid clears, in_ready = 1 next cycle. No input is accepted that cycle because in_ready = 0.
- Main emitting, no accept, skid empty: out_valid clears.
- Entry ordering is strict FIFO; no entry is duplicated or reordered.
- out_ctrl = stored ctrl AND {5{out_valid}}. Control bits are never 1 while out_valid = 0.
- Data fields (target, result, wdata, rd, funct3, zero, pos) keep their last value when invalid.
- flush = 1: at the next edge, main_valid = skid_valid = 0 and stored ctrl of both entries = 0. An input handshaken in the same cycle is discarded. Data fields are don't-care.
- Priority: reset > flush > handshake.
- stall_cnt increments each cycle with out_valid && !out_ready && !flush and saturates at 2^CNT_W−1. It is cleared only by reset.

## Timing
- Reset (async assert, sync use after deassert): out_valid = 0, in_ready = 1, all out_* fields = 0, stall_cnt = 0, skid cleared.
- Latency: accept at edge N → out_valid and fields at edge N (visible in cycle N+1). That is 1 cycle, the same as the plain latch.
- Throughput: 1 entry/cycle while out_ready = 1.
- in_ready is a flop output with no combinational path from out_ready. Out-side signals likewise have no combinational input path.
- After the first stall cycle, at most one more entry is accepted. in_ready falls on the edge after the skid fills.
- Reset asserted mid-stall discards both entries immediately (async).

## Test plan
- Reset then stream 4 instructions with out_ready = 1 (results 0x10,0x20,0x30,0x40; ctrl = 5'b00001) → each appears 1 cycle later, in order, in_ready stays 1, stall_cnt = 0.
- Hold out_ready = 0 while sending A (0x111), B (0x222), C → main = A, skid = B, in_ready = 0 after B, C not accepted. Raise out_ready → A, B, then C emitted in order. stall_cnt equals the stall-cycle count.
- Both entries full (ctrl 5'b11111), pulse flush with in_valid = 1 → next cycle out_valid = 0, out_ctrl = 0, in_ready = 1, flushed-cycle input absent.
- CNT_W = 4, hold out_ready = 0 with a valid entry for 20 cycles → stall_cnt stops at 15.
- Assert reset asynchronously mid-stall, between edges → out_valid and stall_cnt are 0 immediately, in_ready = 1.
- XLEN = 32 build, results 0xFFFF_FFFF and 0x8000_0000 → passed bit-exact, no truncation or extension.
